// File: rtl/player_input_arbiter.sv
// First-press arbiter for four player buttons: synchronizes and debounces the raw
// inputs, then latches the winning player and their answer switch byte.
module player_input_arbiter #(
  parameter int DB_COUNT = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  player_btn,
  input  logic [31:0] player_sw,
  input  logic        game_start,
  input  logic        clear,
  output logic        playerInputFlag,
  output logic [1:0]  firstPlayerFlag,
  output logic [7:0]  switchInput
);

  localparam logic [15:0] CNT_MAX = 16'(DB_COUNT - 1);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

  logic [3:0]       btn_s1_q, btn_s2_q;
  logic [31:0]      sw_s1_q, sw_s2_q;
  logic [3:0][7:0]  sw_bytes;
  logic [3:0]       db_q, db_d, db_prev_q;
  logic [3:0][15:0] cnt_q, cnt_d;
  logic [3:0]       press;
  logic [1:0]       win;

  state_t      state_q, state_d;
  logic        flag_q, flag_d;
  logic [1:0]  who_q, who_d;
  logic [7:0]  swin_q, swin_d;

  // Buttons idle high (released), so their synchronizers reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_q <= 4'hF;
      btn_s2_q <= 4'hF;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      btn_s1_q <= player_btn;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= player_sw;
      sw_s2_q  <= sw_s1_q;
    end
  end

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (btn_s2_q[k] == db_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_MAX) begin
        db_d[k]  = btn_s2_q[k];
        cnt_d[k] = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q      <= 4'hF;
      db_prev_q <= 4'hF;
      cnt_q     <= '0;
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  // One-cycle press strobe on the debounced falling edge (buttons are active-low).
  assign press    = db_prev_q & ~db_q;
  assign sw_bytes = sw_s2_q;

  always_comb begin
    win = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (press[k]) win = 2'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    who_d   = who_q;
    swin_d  = swin_q;
    if (!game_start) begin
      state_d = IDLE;
      flag_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (|press) begin
            state_d = LOCKED;
            flag_d  = 1'b1;
            who_d   = win;
            swin_d  = sw_bytes[win];
          end
        end
        LOCKED: begin
          // Presses landing on the re-arm cycle are dropped: ARMED is not yet current.
          if (clear) begin
            state_d = ARMED;
            flag_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          flag_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      flag_q  <= 1'b0;
      who_q   <= 2'd0;
      swin_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      who_q   <= who_d;
      swin_q  <= swin_d;
    end
  end

  assign playerInputFlag = flag_q;
  assign firstPlayerFlag = who_q;
  assign switchInput     = swin_q;

endmodule

// File: tb/tb_player_input_arbiter.sv
// Scoreboard bench for player_input_arbiter with DB_COUNT=4: stimulus queues the
// expected capture (winner, byte, cycle) and a negedge monitor checks captures and holds.
module tb_player_input_arbiter;

  localparam int DB = 4;
  localparam int LAT = DB + 3; // drive at negedge -> E0 is next posedge -> flag after E0+DB+2

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  player_btn = 4'hF;
  logic [31:0] player_sw = 32'hA45C3B17;
  logic        game_start = 1'b0;
  logic        clear = 1'b0;
  logic        playerInputFlag;
  logic [1:0]  firstPlayerFlag;
  logic [7:0]  switchInput;

  typedef struct {
    int         cyc;
    logic [1:0] who;
    logic [7:0] sw;
  } exp_t;

  exp_t       sb[$];
  int         nchk = 0;
  int         nerr = 0;
  int         cyc = 0;
  logic       flag_prev = 1'b0;
  logic [1:0] last_who = 2'd0;
  logic [7:0] last_sw = 8'd0;

  player_input_arbiter #(.DB_COUNT(DB)) dut (
    .clk(clk), .rst(rst), .player_btn(player_btn), .player_sw(player_sw),
    .game_start(game_start), .clear(clear), .playerInputFlag(playerInputFlag),
    .firstPlayerFlag(firstPlayerFlag), .switchInput(switchInput)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_cap(input logic [1:0] who, input logic [7:0] sw);
    exp_t e;
    e.cyc = cyc + LAT;
    e.who = who;
    e.sw  = sw;
    sb.push_back(e);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  // Monitor: every rising flag must match the oldest queued expectation; held flag must not drift.
  always @(negedge clk) begin
    if (rst) begin
      flag_prev = 1'b0;
    end else begin
      if (playerInputFlag && !flag_prev) begin
        if (sb.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_capture who=%0d sw=%0h expected none (t=%0t)",
                   firstPlayerFlag, switchInput, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("cap_who", firstPlayerFlag, e.who);
          check("cap_sw", switchInput, e.sw);
          check("cap_latency_cycle", cyc, e.cyc);
          last_who = e.who;
          last_sw  = e.sw;
        end
      end else if (playerInputFlag && flag_prev) begin
        check("hold_who", firstPlayerFlag, last_who);
        check("hold_sw", switchInput, last_sw);
      end
      flag_prev = playerInputFlag;
    end
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_flag", playerInputFlag, 0);
    check("rst_who", firstPlayerFlag, 0);
    check("rst_sw", switchInput, 0);
    tick(3);
    rst = 1'b0;
    tick(2);
    check("post_rst_flag", playerInputFlag, 0);

    // Player 3 alone
    game_start = 1'b1;
    tick(3);
    expect_cap(2'd2, 8'h5C);
    player_btn[2] = 1'b0;
    tick(10);
    check("p3_flag", playerInputFlag, 1);
    player_sw = 32'hFFFFFFFF;        // must be ignored while locked
    tick(4);
    player_btn[2] = 1'b1;
    pulse_clear();
    tick(1);
    check("clr_flag", playerInputFlag, 0);
    check("clr_who_kept", firstPlayerFlag, 2);
    check("clr_sw_kept", switchInput, 8'h5C);
    player_sw = 32'hA45C3B17;
    tick(10);

    // Players 2 and 4 together, then player 1 while locked
    expect_cap(2'd1, 8'h3B);
    player_btn[1] = 1'b0;
    player_btn[3] = 1'b0;
    tick(10);
    check("p24_flag", playerInputFlag, 1);
    player_btn[0] = 1'b0;
    player_sw = 32'h01020304;
    tick(10);
    check("locked_who", firstPlayerFlag, 1);
    check("locked_sw", switchInput, 8'h3B);
    player_btn = 4'hF;
    tick(2);
    pulse_clear();
    tick(10);

    // Short glitch on player 1
    player_btn[0] = 1'b0;
    tick(3);
    player_btn[0] = 1'b1;
    tick(10);
    check("glitch_flag", playerInputFlag, 0);

    // Player 4 held across IDLE->ARMED, then release and re-press
    player_sw = 32'h11223344;
    game_start = 1'b0;
    tick(1);
    player_btn[3] = 1'b0;
    tick(10);
    game_start = 1'b1;
    tick(10);
    check("held_no_win", playerInputFlag, 0);
    player_btn[3] = 1'b1;
    tick(10);
    expect_cap(2'd3, 8'h11);
    player_btn[3] = 1'b0;
    tick(10);
    check("p4_flag", playerInputFlag, 1);

    // Clear, re-lock on player 1, then clear with game_start low
    pulse_clear();
    tick(1);
    check("clr2_flag", playerInputFlag, 0);
    check("clr2_who_kept", firstPlayerFlag, 3);
    player_btn[3] = 1'b1;
    tick(10);
    expect_cap(2'd0, 8'h44);
    player_btn[0] = 1'b0;
    tick(10);
    check("p1_flag", playerInputFlag, 1);
    clear = 1'b1;
    game_start = 1'b0;
    tick(1);
    clear = 1'b0;
    check("idle_flag", playerInputFlag, 0);
    check("idle_who_kept", firstPlayerFlag, 0);
    check("idle_sw_kept", switchInput, 8'h44);
    player_btn[0] = 1'b1;
    tick(10);
    player_btn[2] = 1'b0;            // press while idle: no capture
    tick(10);
    check("idle_press_flag", playerInputFlag, 0);
    player_btn[2] = 1'b1;
    tick(10);

    // Lock on player 3, then asynchronous reset between edges
    game_start = 1'b1;
    tick(3);
    expect_cap(2'd2, 8'h22);
    player_btn[2] = 1'b0;
    tick(10);
    check("p3b_flag", playerInputFlag, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    game_start = 1'b0;
    #1;
    check("arst_flag", playerInputFlag, 0);
    check("arst_who", firstPlayerFlag, 0);
    check("arst_sw", switchInput, 0);
    #1 rst = 1'b0;
    tick(1);
    player_btn[1] = 1'b0;
    tick(12);
    check("post_arst_flag", playerInputFlag, 0);
    check("post_arst_who", firstPlayerFlag, 0);
    game_start = 1'b1;
    tick(10);
    check("post_arst_armed_flag", playerInputFlag, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
